uart_rx_multi: RTL
==================

UART_RX_MULTI -- requirements
Module: uart_rx_multi

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame (legal 5..9).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, receive FIFO entries (power of 2, >=2).
REQ-003 SHALL have parameter BAUD_W, default 13, width of baud divisor.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port RX  input  1  asynchronous serial line, idle high.
REQ-007 SHALL have port baudrate  input  BAUD_W  clk cycles per bit.
REQ-008 SHALL have port stop2  input  1  1 = two stop bits expected.
REQ-009 SHALL have port parity_odd  input  1  parity sense, 1 = odd (used only when parity compiled in).
REQ-010 SHALL have port rd_en  input  1  pop FIFO head.
REQ-011 SHALL have port clr_err  input  1  clear sticky error flags.
REQ-012 SHALL have port rx_data  output  DATA_W  FIFO head, first-word fall-through.
REQ-013 SHALL have port rdy  output  1  FIFO non-empty.
REQ-014 SHALL have port count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-015 SHALL have ports frame_err, parity_err, overrun  output  1 each  sticky error flags.

Function
REQ-016 SHALL double-flop RX; both flops load 1 on reset; all decisions use the second flop.
REQ-017 SHALL implement states IDLE, START, DATA, PARITY, STOP.
REQ-018 IDLE: synced RX low -> START, latch baudrate, load baud counter with baudrate/2 - 1.
REQ-019 START: at counter zero, RX high -> IDLE (false start, no flag); RX low -> DATA.
REQ-020 Each bit period SHALL reload the counter with latched baudrate - 1; bit sampled when the counter reaches zero (mid-bit).
REQ-021 DATA SHALL shift DATA_W bits LSB-first, then -> PARITY if compiled in, else STOP.
REQ-022 STOP SHALL sample one stop bit, or two when stop2 was high at start detect; any stop sample low sets frame_err and discards the frame.
REQ-023 After the last stop sample: -> IDLE same cycle, no wait for bit end; good frame pushed to FIFO that edge; rdy high the next cycle.
REQ-024 Push when FIFO full and no pop SHALL drop the new frame and set overrun; FIFO contents unchanged.
REQ-025 Simultaneous push and pop when full SHALL succeed with no overrun; count unchanged.
REQ-026 rd_en while empty SHALL be ignored; rx_data undefined-but-stable while empty.
REQ-027 Counters/pointers SHALL wrap modulo FIFO_DEPTH; count saturates at neither end by construction.
REQ-028 clr_err coincident with a new error SHALL leave that flag set.
REQ-029 baudrate changes mid-frame SHALL not affect the current frame; baudrate < 4 unsupported.

Reset
REQ-030 rst SHALL force IDLE, empty FIFO (count=0, rdy=0), all error flags 0, rx_data 0, including mid-frame.

Configuration
REQ-031 With UART_RX_PARITY_EN defined: PARITY state samples one bit after data; mismatch vs parity_odd sets parity_err and discards the frame.
REQ-032 Without UART_RX_PARITY_EN: no PARITY state, parity_odd unused, parity_err tied 0.

Structure
REQ-033 Package uart_pkg SHALL hold the state enum and parity/stop encodings shared with the transmitter.
REQ-034 FIFO SHALL be a sub-module uart_rx_fifo (parameters DATA_W, FIFO_DEPTH).

Verification
REQ-035 baudrate=16, 8N1 frame 0xA5 -> rdy=1 the cycle after stop sample, rx_data=0xA5, count=1; rd_en one cycle -> rdy=0.
REQ-036 RX low 4 cycles at baudrate=16 -> no push, no flag, state back to IDLE.
REQ-037 Frame 0x3C with stop bit 0 -> frame_err=1, count=0; clr_err -> frame_err=0.
REQ-038 Five frames 0x01..0x05, FIFO_DEPTH=4, no reads -> overrun=1, reads return 0x01..0x04.
REQ-039 UART_RX_PARITY_EN, parity_odd=1, frame 0x07 with parity 1 -> parity_err=1, no push; parity 0 -> accepted.
REQ-040 rst asserted mid-DATA then 8N1 frame 0x5A -> clean receive of 0x5A, no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding plus the parity and stop-bit
// encodings that the matching transmitter also uses.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;
    localparam logic STOP_ONE    = 1'b0;
    localparam logic STOP_TWO    = 1'b1;

    // True when the data bits plus the parity bit carry the requested parity sense.
    function automatic logic parity_ok(input logic data_xor, input logic par_bit,
                                       input logic odd);
        return (data_xor ^ par_bit) == odd;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive FIFO, first-word fall-through. A push into a full FIFO is dropped and
// reported on overflow unless a pop happens in the same cycle.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_W-1:0]             push_data,
    input  logic                          pop,
    output logic [DATA_W-1:0]             rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          empty,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              full, do_push, do_pop;

    always_comb begin
        full     = (count_q == CW'(FIFO_DEPTH));
        empty    = (count_q == '0);
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        overflow = push && full && !do_pop;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        // Pointers are exactly AW bits wide, so they wrap modulo the depth.
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;

endmodule

// File: rtl/uart_rx_multi.sv
// UART receiver with configurable frame format and a receive FIFO.
// Define UART_RX_PARITY_EN to add a parity bit after the data bits.
module uart_rx_multi
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int BAUD_W     = 13
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         RX,
    input  logic [BAUD_W-1:0]            baudrate,
    input  logic                         stop2,
    input  logic                         parity_odd,
    input  logic                         rd_en,
    input  logic                         clr_err,
    output logic [DATA_W-1:0]            rx_data,
    output logic                         rdy,
    output logic [$clog2(FIFO_DEPTH):0]  count,
    output logic                         frame_err,
    output logic                         parity_err,
    output logic                         overrun,
    output logic [2:0]                   state_dbg
);
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);
`ifdef UART_RX_PARITY_EN
    localparam uart_state_e DATA_NEXT = ST_PARITY;
`else
    localparam uart_state_e DATA_NEXT = ST_STOP;
`endif

    uart_state_e       state_q, state_d;
    logic              rx_s1_q, rx_s2_q;
    logic [BAUD_W-1:0] cnt_q, cnt_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
    logic              stop2_lat_q, stop2_lat_d;
    logic              stop_idx_q, stop_idx_d;
    logic              bad_q, bad_d;
    logic              frame_err_q, frame_err_d;
    logic              overrun_q, overrun_d;
    logic              tick, last_bit, last_stop;
    logic              push, set_frame, set_parity, fifo_overflow, fifo_empty;

    assign tick      = (cnt_q == '0);
    assign last_bit  = (bit_idx_q == LAST_IDX);
    assign last_stop = !stop2_lat_q || stop_idx_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (!rx_s2_q) state_d = ST_START;
            ST_START:  if (tick) state_d = rx_s2_q ? ST_IDLE : ST_DATA;
            ST_DATA:   if (tick && last_bit) state_d = DATA_NEXT;
`ifdef UART_RX_PARITY_EN
            ST_PARITY: if (tick) state_d = ST_STOP;
`endif
            ST_STOP:   if (tick && last_stop) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

`ifdef UART_RX_PARITY_EN
    logic par_odd_q, par_odd_d;
    logic parity_err_q, parity_err_d;
`else
    logic unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    // Datapath and FSM outputs; bits are sampled when the counter hits zero.
    always_comb begin
        cnt_d       = cnt_q;
        baud_d      = baud_q;
        shreg_d     = shreg_q;
        bit_idx_d   = bit_idx_q;
        stop2_lat_d = stop2_lat_q;
        stop_idx_d  = stop_idx_q;
        bad_d       = bad_q;
        push        = 1'b0;
        set_frame   = 1'b0;
        set_parity  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_odd_d   = par_odd_q;
`endif
        if (state_q != ST_IDLE && !tick) begin
            cnt_d = cnt_q - BAUD_W'(1);
        end
        unique case (state_q)
            ST_IDLE: begin
                if (!rx_s2_q) begin
                    baud_d      = baudrate;
                    cnt_d       = (baudrate >> 1) - BAUD_W'(1);
                    stop2_lat_d = stop2;
                    bit_idx_d   = '0;
                    stop_idx_d  = 1'b0;
                    bad_d       = 1'b0;
`ifdef UART_RX_PARITY_EN
                    par_odd_d   = parity_odd;
`endif
                end
            end
            ST_START: begin
                if (tick) cnt_d = baud_q - BAUD_W'(1);
            end
            ST_DATA: begin
                if (tick) begin
                    cnt_d     = baud_q - BAUD_W'(1);
                    shreg_d   = {rx_s2_q, shreg_q[DATA_W-1:1]};
                    bit_idx_d = bit_idx_q + IDX_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick) begin
                    cnt_d = baud_q - BAUD_W'(1);
                    if (!parity_ok(^shreg_q, rx_s2_q, par_odd_q)) begin
                        set_parity = 1'b1;
                        bad_d      = 1'b1;
                    end
                end
            end
`endif
            ST_STOP: begin
                if (tick) begin
                    cnt_d      = baud_q - BAUD_W'(1);
                    stop_idx_d = 1'b1;
                    if (!rx_s2_q) begin
                        set_frame = 1'b1;
                        bad_d     = 1'b1;
                    end
                    push = last_stop && rx_s2_q && !bad_q;
                end
            end
            default: ;
        endcase
    end

    // A new error in the same cycle as clr_err wins.
    always_comb begin
        frame_err_d = (frame_err_q & ~clr_err) | set_frame;
        overrun_d   = (overrun_q & ~clr_err) | fifo_overflow;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            cnt_q       <= '0;
            baud_q      <= '0;
            shreg_q     <= '0;
            bit_idx_q   <= '0;
            stop2_lat_q <= 1'b0;
            stop_idx_q  <= 1'b0;
            bad_q       <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_s1_q     <= RX;
            rx_s2_q     <= rx_s1_q;
            cnt_q       <= cnt_d;
            baud_q      <= baud_d;
            shreg_q     <= shreg_d;
            bit_idx_q   <= bit_idx_d;
            stop2_lat_q <= stop2_lat_d;
            stop_idx_q  <= stop_idx_d;
            bad_q       <= bad_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    assign parity_err_d = (parity_err_q & ~clr_err) | set_parity;
    always_ff @(posedge clk) begin
        if (rst) begin
            par_odd_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_odd_q    <= par_odd_d;
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    // Read side: rx_data is the head while rdy; rd_en pops it, and is ignored when empty.
    uart_rx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (shreg_q),
        .pop       (rd_en),
        .rd_data   (rx_data),
        .count     (count),
        .empty     (fifo_empty),
        .overflow  (fifo_overflow)
    );

    assign rdy       = !fifo_empty;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign state_dbg = state_q;

endmodule
